// File: rtl/squarer_rr_scheduler.sv
// squarer_rr_scheduler: round-robin arbiter that shares one 4-bit squarer
// between NUM_REQ requesters over valid/ready handshakes.
// Optional build macro: SQUARER_SCHED_CHECK_EN. When defined, a behavioural
// product cross-checks the squarer and raises the sticky chk_err flag.

// Combinational 4-bit squarer. The shift-and-add form mirrors the
// reversible datapath; g is the garbage output, an unmodified copy of a.
module squarer_4bit (
  input  logic [3:0] a,
  output logic [7:0] y,
  output logic [3:0] g
);

  // Sum the partial products a * (a[i] << i)
  always_comb begin
    y = '0;
    for (int i = 0; i < 4; i++) begin
      if (a[i]) y = y + (8'(a) << i);
    end
  end

  assign g = a;

endmodule

module squarer_rr_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_a,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [7:0]           rsp_y,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy,
  output logic                 chk_err
);

  typedef enum logic [1:0] {StIdle, StCapt, StResp} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    id_q;
  logic [3:0]         a_q;
  logic [7:0]         rsp_y_q;
  logic [ID_W-1:0]    rsp_id_q;

  logic               found;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    idx;
  logic [3:0]         win_a;
  logic [NUM_REQ-1:0] grant_oh;
  logic               can_grant;
  logic [7:0]         sq_y;

  // Only the captured operand ever reaches the squarer
  squarer_4bit u_squarer (
    .a (a_q),
    .y (sq_y),
    .g ()
  );

  // Round-robin search: first valid requester at or after rr_ptr_q
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (int'(rr_ptr_q) + k >= int'(NUM_REQ)) begin
        idx = ID_W'(int'(rr_ptr_q) + k - int'(NUM_REQ));
      end else begin
        idx = ID_W'(int'(rr_ptr_q) + k);
      end
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Winner operand mux and one-hot grant vector
  always_comb begin
    win_a    = '0;
    grant_oh = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (winner == ID_W'(i)) begin
        win_a       = req_a[4*i +: 4];
        grant_oh[i] = 1'b1;
      end
    end
  end

  // Grants happen from IDLE, or from RESP in the cycle the response drains
  always_comb begin
    can_grant = !rst && found &&
                ((state_q == StIdle) || ((state_q == StResp) && rsp_ready));
    req_ready = can_grant ? grant_oh : '0;
    rr_ptr_d  = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (can_grant) state_d = StCapt;
      StCapt: state_d = StResp;
      StResp: if (rsp_ready) state_d = can_grant ? StCapt : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, capture and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      a_q      <= '0;
      id_q     <= '0;
      rsp_y_q  <= '0;
      rsp_id_q <= '0;
    end else begin
      state_q <= state_d;
      if (can_grant) begin
        a_q      <= win_a;
        id_q     <= winner;
        rr_ptr_q <= rr_ptr_d;
      end
      if (state_q == StCapt) begin
        rsp_y_q  <= sq_y;
        rsp_id_q <= id_q;
      end
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_y     = rsp_y_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = !rst && (state_q != StIdle);

`ifdef SQUARER_SCHED_CHECK_EN
  logic chk_err_q;

  // Sticky flag: squarer disagrees with the behavioural product in CAPT
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_err_q <= 1'b0;
    end else if ((state_q == StCapt) && (sq_y != (8'(a_q) * 8'(a_q)))) begin
      chk_err_q <= 1'b1;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_squarer_rr_scheduler.sv
// Directed bench for squarer_rr_scheduler: per-cycle vector table covering
// single request, round-robin order, backpressure and mid-CAPT reset,
// followed by an exhaustive operand sweep from requester 0.
module tb_squarer_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_y;
  logic [1:0]  rsp_id;
  logic        busy;
  logic        chk_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  squarer_rr_scheduler #(
    .NUM_REQ (4),
    .ID_W    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .chk_err   (chk_err)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [15:0] a;
    logic        rr;
    logic [3:0]  e_rdy;
    logic        e_rv;
    logic [7:0]  e_y;
    logic [1:0]  e_id;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] v, input logic [15:0] a,
                     input logic rr, input logic [3:0] erdy, input logic erv,
                     input logic [7:0] ey, input logic [1:0] eid, input logic eb);
    vec_t t;
    t.rst = r; t.vld = v; t.a = a; t.rr = rr;
    t.e_rdy = erdy; t.e_rv = erv; t.e_y = ey; t.e_id = eid; t.e_busy = eb;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  initial begin
    logic [16:0] got, exp;
    rst = 1'b1; req_valid = '0; req_a = '0; rsp_ready = 1'b0;
    //   rst vld      a         rr  rdy      rv  y     id  busy
    // single request: requester 2, a=13
    add(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 8'd0,   0, 0); // 0 reset state
    add(0, 4'b0100, 16'h0D00, 1, 4'b0100, 0, 8'd0,   0, 0); // 1 grant 2
    add(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 8'd0,   0, 1); // 2 CAPT
    add(0, 4'b0000, 16'h0000, 1, 4'b0000, 1, 8'd169, 2, 1); // 3 RESP
    // pointer now 3; all valid with operands 1,2,3,15
    add(0, 4'b1111, 16'hF321, 1, 4'b1000, 0, 8'd169, 2, 0); // 4 grant 3
    add(0, 4'b1111, 16'hF321, 1, 4'b0000, 0, 8'd169, 2, 1); // 5
    add(0, 4'b1111, 16'hF321, 1, 4'b0001, 1, 8'd225, 3, 1); // 6 grant 0
    add(0, 4'b1111, 16'hF321, 1, 4'b0000, 0, 8'd225, 3, 1); // 7
    add(0, 4'b1111, 16'hF321, 1, 4'b0010, 1, 8'd1,   0, 1); // 8 grant 1
    add(0, 4'b1111, 16'hF321, 1, 4'b0000, 0, 8'd1,   0, 1); // 9
    add(0, 4'b1111, 16'hF321, 1, 4'b0100, 1, 8'd4,   1, 1); // 10 grant 2
    add(0, 4'b1111, 16'hF321, 1, 4'b0000, 0, 8'd4,   1, 1); // 11
    add(0, 4'b1111, 16'hF321, 1, 4'b1000, 1, 8'd9,   2, 1); // 12 grant 3
    add(0, 4'b1111, 16'hF321, 1, 4'b0000, 0, 8'd9,   2, 1); // 13
    add(0, 4'b1111, 16'hF321, 1, 4'b0001, 1, 8'd225, 3, 1); // 14 grant 0
    add(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 8'd225, 3, 1); // 15
    add(0, 4'b0000, 16'h0000, 1, 4'b0000, 1, 8'd1,   0, 1); // 16 -> IDLE
    // backpressure: requester 0 with a=7, then requester 1 waits
    add(0, 4'b0001, 16'h0007, 0, 4'b0001, 0, 8'd1,   0, 0); // 17 grant 0
    add(0, 4'b0000, 16'h0000, 0, 4'b0000, 0, 8'd1,   0, 1); // 18 CAPT
    for (int i = 0; i < 5; i++)
      add(0, 4'b0010, 16'h00A0, 0, 4'b0000, 1, 8'd49, 0, 1); // 19..23 held
    add(0, 4'b0010, 16'h00A0, 1, 4'b0010, 1, 8'd49,  0, 1); // 24 xfer+grant 1
    add(0, 4'b0000, 16'h0000, 0, 4'b0000, 0, 8'd49,  0, 1); // 25 CAPT
    add(0, 4'b0000, 16'h0000, 0, 4'b0000, 1, 8'd100, 1, 1); // 26 RESP held
    // reset during CAPT
    add(0, 4'b0100, 16'h0500, 1, 4'b0100, 1, 8'd100, 1, 1); // 27 grant 2
    add(1, 4'b1111, 16'hF321, 1, 4'b0000, 0, 8'd100, 1, 0); // 28 rst in CAPT
    add(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 8'd0,   0, 0); // 29 cleared
    add(0, 4'b1111, 16'hF321, 1, 4'b0001, 0, 8'd0,   0, 0); // 30 ptr back to 0
    add(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 8'd0,   0, 1); // 31 CAPT
    add(0, 4'b0000, 16'h0000, 1, 4'b0000, 1, 8'd1,   0, 1); // 32 RESP -> IDLE

    @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      rst = vecs[i].rst; req_valid = vecs[i].vld; req_a = vecs[i].a;
      rsp_ready = vecs[i].rr;
      @(negedge clk);
      got = {req_ready, rsp_valid, rsp_y, rsp_id, busy, chk_err};
      exp = {vecs[i].e_rdy, vecs[i].e_rv, vecs[i].e_y, vecs[i].e_id, vecs[i].e_busy, 1'b0};
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL vec%0d {rdy,rv,y,id,busy,err}: got %h expected %h", i, got, exp);
    end

    // Exhaustive operand sweep from requester 0 (pointer sits at 1)
    for (int a = 0; a < 16; a++) begin
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 4'b0001; req_a = {12'h000, 4'(a)}; rsp_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("exh_grant_%0d", a), 32'(req_ready), 32'h1);
      @(posedge clk); #1;
      req_valid = '0; req_a = '0;
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("exh_rsp_%0d", a), {21'd0, rsp_valid, rsp_id, rsp_y},
          {21'd0, 1'b1, 2'd0, 8'(a * a)});
    end
    chk("chk_err_final", 32'(chk_err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
